// File: rtl/dspcplx_mult_sched.sv
// Round-robin scheduler that time-shares one pipelined complex multiplier among
// NREQ requesters. Operands are accepted over valid/ready and registered into the
// multiplier. A requester-ID tag travels beside each op so the product returns
// tagged to its owner. An enable/drain FSM lets software quiesce the multiplier.
module dspcplx_mult_sched #(
  parameter int NREQ     = 4,
  parameter int AW       = 18,
  parameter int BW       = 18,
  parameter int MULT_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*AW-1:0]        req_ar,
  input  logic [NREQ*AW-1:0]        req_ai,
  input  logic [NREQ*BW-1:0]        req_br,
  input  logic [NREQ*BW-1:0]        req_bi,
  output logic [AW-1:0]             mul_ar,
  output logic [AW-1:0]             mul_ai,
  output logic [BW-1:0]             mul_br,
  output logic [BW-1:0]             mul_bi,
  input  logic [AW+BW+1:0]          mul_pr,
  input  logic [AW+BW+1:0]          mul_pi,
  output logic                      res_valid,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [AW+BW+1:0]          res_pr,
  output logic [AW+BW+1:0]          res_pi,
  output logic                      idle
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = AW + BW + 2;
  // One op in the issue register plus one per multiplier stage can be in flight.
  localparam int IFW = $clog2(MULT_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             w_grant_en;
  logic             w_gnt;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_idx;
  logic [AW-1:0]    w_sel_ar, w_sel_ai;
  logic [BW-1:0]    w_sel_br, w_sel_bi;
  logic [IDW-1:0]   r_ptr;
  logic [IFW-1:0]   r_inflight;

  logic [AW-1:0]    r_mul_ar, r_mul_ai;
  logic [BW-1:0]    r_mul_br, r_mul_bi;
  // Issue-stage tag rides with r_mul_*; r_tag_* then mirrors the multiplier's
  // MULT_LAT stages so the last entry lines up with mul_pr/mul_pi.
  logic             r_iss_v;
  logic [IDW-1:0]   r_iss_id;
  logic [MULT_LAT-1:0] r_tag_v;
  logic [IDW-1:0]   r_tag_id [MULT_LAT];

  logic             r_res_valid;
  logic [IDW-1:0]   r_res_id;
  logic [PW-1:0]    r_res_pr, r_res_pi;

  logic             w_ret_v;
  assign w_ret_v = r_tag_v[MULT_LAT-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; granting is allowed only while running with en held high.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    unique case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN: begin
        w_grant_en = en;
        if (!en) w_state_nxt = (r_inflight == '0) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: if (r_inflight == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign idle = (r_state == S_IDLE);

  // Round-robin search starting one past the last granted requester, plus the
  // operand mux for the winner.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    req_ready = '0;
    w_sel_ar  = '0;
    w_sel_ai  = '0;
    w_sel_br  = '0;
    w_sel_bi  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (w_grant_en && !w_gnt && req_valid[w_idx]) begin
        w_gnt    = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (w_gnt) req_ready[w_gnt_id] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_sel_ar = req_ar[i*AW +: AW];
        w_sel_ai = req_ai[i*AW +: AW];
        w_sel_br = req_br[i*BW +: BW];
        w_sel_bi = req_bi[i*BW +: BW];
      end
    end
  end

  // Round-robin pointer follows the most recent transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= IDW'(NREQ - 1);
    else if (w_gnt) r_ptr <= w_gnt_id;
  end

  // Operand registers feeding the multiplier; hold when nothing transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_ar <= '0;
      r_mul_ai <= '0;
      r_mul_br <= '0;
      r_mul_bi <= '0;
    end else if (w_gnt) begin
      r_mul_ar <= w_sel_ar;
      r_mul_ai <= w_sel_ai;
      r_mul_br <= w_sel_br;
      r_mul_bi <= w_sel_bi;
    end
  end

  assign mul_ar = r_mul_ar;
  assign mul_ai = r_mul_ai;
  assign mul_br = r_mul_br;
  assign mul_bi = r_mul_bi;

  // Tag pipeline carrying valid/ID in lockstep with the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_v  <= 1'b0;
      r_iss_id <= '0;
      r_tag_v  <= '0;
      // NOTE: this small array is reset because its valids must clear on reset;
      // large data-only memories would normally be left unreset.
      for (int j = 0; j < MULT_LAT; j++) r_tag_id[j] <= '0;
    end else begin
      r_iss_v <= w_gnt;
      if (w_gnt) r_iss_id <= w_gnt_id;
      r_tag_v[0]  <= r_iss_v;
      r_tag_id[0] <= r_iss_id;
      for (int j = 1; j < MULT_LAT; j++) begin
        r_tag_v[j]  <= r_tag_v[j-1];
        r_tag_id[j] <= r_tag_id[j-1];
      end
    end
  end

  // Result register: product captured only when its tag is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_pr    <= '0;
      r_res_pi    <= '0;
    end else begin
      r_res_valid <= w_ret_v;
      r_res_id    <= r_tag_id[MULT_LAT-1];
      if (w_ret_v) begin
        r_res_pr <= mul_pr;
        r_res_pi <= mul_pi;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_pr    = r_res_pr;
  assign res_pi    = r_res_pi;

  // In-flight counter used by the drain logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_inflight <= '0;
    else begin
      unique case ({w_gnt, w_ret_v})
        2'b10:   r_inflight <= r_inflight + IFW'(1);
        2'b01:   r_inflight <= r_inflight - IFW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_dspcplx_mult_sched.sv
// Directed bench for dspcplx_mult_sched with a behavioural pipelined complex
// multiplier attached to the mul_* ports.
module tb_dspcplx_mult_sched;

  localparam int NREQ     = 4;
  localparam int AW       = 18;
  localparam int BW       = 18;
  localparam int MULT_LAT = 4;
  localparam int IDW      = 2;
  localparam int PW       = AW + BW + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en  = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_ar = '0, req_ai = '0;
  logic [NREQ*BW-1:0]   req_br = '0, req_bi = '0;
  logic [AW-1:0]        mul_ar, mul_ai;
  logic [BW-1:0]        mul_br, mul_bi;
  logic [PW-1:0]        mul_pr, mul_pi;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [PW-1:0]        res_pr, res_pi;
  logic                 idle;

  dspcplx_mult_sched #(
    .NREQ(NREQ), .AW(AW), .BW(BW), .MULT_LAT(MULT_LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ar(req_ar), .req_ai(req_ai), .req_br(req_br), .req_bi(req_bi),
    .mul_ar(mul_ar), .mul_ai(mul_ai), .mul_br(mul_br), .mul_bi(mul_bi),
    .mul_pr(mul_pr), .mul_pi(mul_pi),
    .res_valid(res_valid), .res_id(res_id), .res_pr(res_pr), .res_pi(res_pi),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // Behavioural complex multiplier: MULT_LAT edges from mul_* to mul_pr/mul_pi.
  logic signed [PW-1:0] x_ar, x_ai, x_br, x_bi;
  logic signed [PW-1:0] m_pr [MULT_LAT];
  logic signed [PW-1:0] m_pi [MULT_LAT];
  assign x_ar = $signed(mul_ar);
  assign x_ai = $signed(mul_ai);
  assign x_br = $signed(mul_br);
  assign x_bi = $signed(mul_bi);
  always @(posedge clk) begin
    m_pr[0] <= x_ar * x_br - x_ai * x_bi;
    m_pi[0] <= x_ar * x_bi + x_ai * x_br;
    for (int j = 1; j < MULT_LAT; j++) begin
      m_pr[j] <= m_pr[j-1];
      m_pi[j] <= m_pi[j-1];
    end
  end
  assign mul_pr = m_pr[MULT_LAT-1];
  assign mul_pi = m_pi[MULT_LAT-1];

  // Result monitor: records every delivered product and the longest valid run.
  int unsigned       got_id [$];
  int                got_pr [$];
  int                got_pi [$];
  int                run_len = 0;
  int                max_run = 0;
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      got_id.push_back(int'(res_id));
      got_pr.push_back(int'($signed(res_pr)));
      got_pi.push_back(int'($signed(res_pi)));
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int ar, input int ai,
                         input int br, input int bi);
    req_ar[i*AW +: AW] = AW'(ar);
    req_ai[i*AW +: AW] = AW'(ai);
    req_br[i*BW +: BW] = BW'(br);
    req_bi[i*BW +: BW] = BW'(bi);
  endtask

  task automatic clear_log();
    got_id.delete();
    got_pr.delete();
    got_pi.delete();
    max_run = 0;
  endtask

  task automatic do_reset();
    en        = 1'b0;
    req_valid = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 40 && got_id.size() < n; c++) tick();
    tick();
    tick();
  endtask

  // Hand-computed products for the standard operand set of each requester.
  int exp_pr [NREQ] = '{-5, -9, -300, 5014};
  int exp_pi [NREQ] = '{10, 17, 600, -6990};

  task automatic load_std_ops();
    set_req(0, 1, 2, 3, 4);
    set_req(1, -7, 5, 2, -1);
    set_req(2, 100, 0, -3, 6);
    set_req(3, -1000, -2, -5, 7);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_rdy3 [6] = '{4, 4, 8, 1, 8, 1};
    int          vld3     [6] = '{4, 4, 9, 9, 9, 9};
    int unsigned exp_id3  [6] = '{2, 2, 3, 0, 3, 0};
    logic        prev_rv, seen_idle, bad_ready;

    // ---- Reset values ----
    #1 rst = 1'b1;
    #2;
    chk("rst_idle", idle, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_pr", res_pr, 0);
    chk("rst_mul_ar", mul_ar, 0);
    tick();
    rst = 1'b0;

    // ---- Test 1: single op latency and product ----
    set_req(0, 3, 4, 5, -2);
    en = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("t1_no_grant_in_idle", req_ready, 0);
    tick();
    chk("t1_ready0", req_ready, 1);
    tick();
    req_valid = '0;
    chk("t1_mul_ar", $signed(mul_ar), 3);
    chk("t1_mul_bi", $signed(mul_bi), -2);
    repeat (4) tick();
    chk("t1_res_not_yet", res_valid, 0);
    chk("t1_idle_busy", idle, 0);
    tick();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_id", res_id, 0);
    chk("t1_res_pr", $signed(res_pr), 23);
    chk("t1_res_pi", $signed(res_pi), 14);
    tick();
    chk("t1_res_once", res_valid, 0);

    // ---- Test 2: all four requesting, strict rotation ----
    do_reset();
    load_std_ops();
    en = 1'b1;
    tick();
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("t2_ready%0d", c), req_ready, 1 << (c % 4));
      tick();
    end
    req_valid = '0;
    wait_results(8);
    chk("t2_count", got_id.size(), 8);
    chk("t2_run", max_run, 8);
    for (int c = 0; c < 8 && c < got_id.size(); c++) begin
      chk($sformatf("t2_id%0d", c), got_id[c], c % 4);
      chk($sformatf("t2_pr%0d", c), got_pr[c], exp_pr[c % 4]);
      chk($sformatf("t2_pi%0d", c), got_pi[c], exp_pi[c % 4]);
    end

    // ---- Test 3: lone requester, then others join ----
    do_reset();
    en = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      req_valid = NREQ'(vld3[c]);
      #1;
      chk($sformatf("t3_ready%0d", c), req_ready, exp_rdy3[c]);
      tick();
    end
    req_valid = '0;
    wait_results(6);
    chk("t3_count", got_id.size(), 6);
    for (int c = 0; c < 6 && c < got_id.size(); c++)
      chk($sformatf("t3_id%0d", c), got_id[c], exp_id3[c]);

    // ---- Test 4: drain with three ops in flight ----
    do_reset();
    en = 1'b1;
    tick();
    req_valid = 4'b0010;
    #1;
    chk("t4_ready1", req_ready, 2);
    repeat (3) tick();
    en = 1'b0;
    #1;
    chk("t4_no_ready_en0", req_ready, 0);
    tick();
    chk("t4_draining", idle, 0);
    en = 1'b1;
    prev_rv   = 1'b0;
    seen_idle = 1'b0;
    bad_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      prev_rv = res_valid;
      tick();
      if (req_ready != '0) bad_ready = 1'b1;
      if (idle) begin
        seen_idle = 1'b1;
        break;
      end
    end
    chk("t4_reached_idle", seen_idle, 1);
    chk("t4_idle_after_last", prev_rv, 1);
    chk("t4_no_grant_drain", bad_ready, 0);
    chk("t4_count", got_id.size(), 3);
    chk("t4_last_id", got_id.size() == 3 ? got_id[2] : 99, 1);
    tick();
    chk("t4_regrant_after_idle", req_ready, 2);
    req_valid = '0;
    en = 1'b0;

    // ---- Test 5: async reset with four ops in flight ----
    do_reset();
    en = 1'b1;
    tick();
    req_valid = 4'b1000;
    repeat (5) tick();
    req_valid = '0;
    tick();
    chk("t5_pre_res_valid", res_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_res_valid", res_valid, 0);
    chk("t5_rst_res_id", res_id, 0);
    chk("t5_rst_res_pr", res_pr, 0);
    chk("t5_rst_mul_ar", mul_ar, 0);
    chk("t5_rst_idle", idle, 1);
    tick();
    rst = 1'b0;
    clear_log();
    repeat (10) tick();
    chk("t5_no_stale_results", got_id.size(), 0);
    en = 1'b1;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (4) tick();
    tick();
    chk("t5_res_valid", res_valid, 1);
    chk("t5_res_id", res_id, 2);
    chk("t5_res_pr", $signed(res_pr), -300);
    chk("t5_res_pi", $signed(res_pi), 600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
